// File: rtl/param_dec_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : param_dec_scan_if
// Description : Control and decode-output bundle for param_dec_scan.
// Revision    : 1.0  initial release
// ============================================================================
interface param_dec_scan_if #(
    parameter int SEL_W = 2
) ();
    localparam int c_n_out = 2 ** SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic               sel_vld;
    logic [c_n_out-1:0] y;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel, sel_vld,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, sel, sel_vld,
        output y, idx, wrap
    );
endinterface
`default_nettype wire

// File: rtl/param_dec_scan.sv
`default_nettype none
// ============================================================================
// Module      : param_dec_scan
// Description : Registered 1-of-N decoder with direct select and auto-scan.
// Revision    : 1.0  initial release
// ============================================================================
module param_dec_scan #(
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4,
    parameter int ACT_LOW  = 0
) (
    input  wire             clk,
    input  wire             rst_n,
    param_dec_scan_if.slave bus
);
    localparam int c_n_out = 2 ** SEL_W;
    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [SEL_W-1:0]   c_idx_last = SEL_W'(c_n_out - 1);
    localparam logic [SEL_W-1:0]   c_idx_one  = SEL_W'(1);
    localparam logic [c_n_out-1:0] c_y_off    = {c_n_out{ACT_LOW != 0}};

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DIRECT     = 2'd1,
        S_SCAN_HOLD  = 2'd2,
        S_SCAN_BLANK = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [c_div_w-1:0] r_div;
    logic [c_div_w-1:0] w_div_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic [c_n_out-1:0] r_y;
    logic [c_n_out-1:0] w_dec;
    logic [c_n_out-1:0] w_y_nxt;
    logic               w_lit;

    // Disable wins over everything; mode then picks direct vs. scan sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_div_nxt   = '0;
        w_wrap_nxt  = 1'b0;
        if (!bus.en) begin
            w_state_nxt = S_IDLE;
        end else if (!bus.mode) begin
            w_state_nxt = S_DIRECT;
            if (bus.sel_vld) begin
                w_idx_nxt = bus.sel;
            end
        end else begin
            case (r_state)
                S_SCAN_HOLD: begin
                    if (r_div == c_div_last) begin
                        w_state_nxt = S_SCAN_BLANK;
                    end else begin
                        w_div_nxt = r_div + c_div_one;
                    end
                end
                S_SCAN_BLANK: begin
                    w_state_nxt = S_SCAN_HOLD;
                    w_idx_nxt   = r_idx + c_idx_one;
                    w_wrap_nxt  = (r_idx == c_idx_last);
                end
                default: begin
                    w_state_nxt = S_SCAN_HOLD;
                    w_idx_nxt   = '0;
                end
            endcase
        end
        w_lit = (w_state_nxt == S_DIRECT) || (w_state_nxt == S_SCAN_HOLD);
    end

    // Decode the next index so y lands in the same cycle as idx.
    for (genvar gi = 0; gi < c_n_out; gi++) begin : g_dec
        localparam logic [SEL_W-1:0] c_code = SEL_W'(gi);
        assign w_dec[gi] = w_lit && (w_idx_nxt == c_code);
    end

    assign w_y_nxt = w_dec ^ c_y_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_div   <= '0;
            r_wrap  <= 1'b0;
            r_y     <= c_y_off;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_div   <= w_div_nxt;
            r_wrap  <= w_wrap_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign bus.y    = r_y;
    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_param_dec_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_dec_scan
// Description : Randomized self-checking bench against a time-based scan model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_param_dec_scan;
    localparam int c_n   = 4;
    localparam int c_div = 2;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    param_dec_scan_if #(.SEL_W(2)) bus  ();
    param_dec_scan_if #(.SEL_W(3)) bus2 ();

    param_dec_scan #(.SEL_W(2), .SCAN_DIV(c_div), .ACT_LOW(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    param_dec_scan #(.SEL_W(3), .SCAN_DIV(1), .ACT_LOW(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 direct, 2 scan; in scan, everything follows from
    // the number of cycles t since scanning started.
    int         m_mode;
    int         m_t;
    int         m_idx;
    logic [3:0] exp_y;
    logic [1:0] exp_idx;
    logic       exp_wrap;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_t      = 0;
        m_idx    = 0;
        exp_y    = '0;
        exp_idx  = '0;
        exp_wrap = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic md, input logic [1:0] s, input logic v);
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!e) begin
            m_mode = 0;
        end else if (!md) begin
            m_mode = 1;
            if (v) m_idx = int'(s);
        end else if (m_mode == 2) begin
            m_t++;
        end else begin
            m_mode = 2;
            m_t    = 0;
        end
        if (m_mode == 2) m_idx = (m_t / (c_div + 1)) % c_n;
        exp_idx  = 2'(m_idx);
        exp_y    = ((m_mode == 1) || (m_mode == 2 && (m_t % (c_div + 1)) != c_div))
                   ? (4'b0001 << m_idx) : 4'b0000;
        exp_wrap = (m_mode == 2) && (m_t > 0) && ((m_t % (c_n * (c_div + 1))) == 0);
    endtask

    task automatic compare_all();
        check("y", 32'(bus.y), 32'(exp_y));
        check("idx", 32'(bus.idx), 32'(exp_idx));
        check("wrap", 32'(bus.wrap), 32'(exp_wrap));
        check("onehot", 32'($countones(bus.y) <= 1), 32'd1);
    endtask

    task automatic step(input logic e, input logic md, input logic [1:0] s, input logic v);
        bus.en      = e;
        bus.mode    = md;
        bus.sel     = s;
        bus.sel_vld = v;
        @(posedge clk);
        model_edge(e, md, s, v);
        #1;
        compare_all();
    endtask

    task automatic step2(input logic e, input logic md, input logic [2:0] s, input logic v);
        bus2.en      = e;
        bus2.mode    = md;
        bus2.sel     = s;
        bus2.sel_vld = v;
        step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #2;
        check("areset_y", 32'(bus.y), 32'd0);
        check("areset_idx", 32'(bus.idx), 32'd0);
        check("areset_wrap", 32'(bus.wrap), 32'd0);
        model_reset();
    endtask

    logic [3:0] scan_tbl [13];
    logic       r_en;
    logic       r_mode;

    initial begin
        n_pass  = 0;
        n_total = 0;
        scan_tbl = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                     4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.sel_vld = 1'b0;
        bus2.en = 1'b0; bus2.mode = 1'b0; bus2.sel = '0; bus2.sel_vld = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_idx", 32'(bus.idx), 32'd0);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        check("rst_y_actlow", 32'(bus2.y), 32'hFF);
        rst_n = 1'b1;

        // Active-low, 8 outputs, one-cycle hold.
        step2(1'b1, 1'b0, 3'd5, 1'b1);
        check("al_direct5", 32'(bus2.y), 32'hDF);
        check("al_idx5", 32'(bus2.idx), 32'd5);
        step2(1'b0, 1'b0, 3'd0, 1'b0);
        check("al_idle", 32'(bus2.y), 32'hFF);
        step2(1'b1, 1'b1, 3'd0, 1'b0);
        check("al_scan0", 32'(bus2.y), 32'hFE);
        step2(1'b1, 1'b1, 3'd0, 1'b0);
        check("al_blank", 32'(bus2.y), 32'hFF);
        step2(1'b1, 1'b1, 3'd0, 1'b0);
        check("al_scan1", 32'(bus2.y), 32'hFD);
        step2(1'b0, 1'b0, 3'd0, 1'b0);

        // Direct capture, then sel change without sel_vld.
        step(1'b1, 1'b0, 2'd3, 1'b1);
        check("dir_y3", 32'(bus.y), 32'h8);
        check("dir_idx3", 32'(bus.idx), 32'd3);
        step(1'b1, 1'b0, 2'd1, 1'b0);
        check("dir_hold", 32'(bus.y), 32'h8);

        // Asynchronous reset from y=0100.
        step(1'b1, 1'b0, 2'd2, 1'b1);
        check("dir_y2", 32'(bus.y), 32'h4);
        async_reset_check();
        step(1'b1, 1'b0, 2'd3, 1'b1);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 2'd0, 1'b0);

        // Full rotation from IDLE.
        for (int k = 0; k < 13; k++) begin
            step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            check("scan_seq", 32'(bus.y), 32'(scan_tbl[k]));
            check("scan_wrap", 32'(bus.wrap), (k == 12) ? 32'd1 : 32'd0);
        end

        // Disable while holding idx 2, then restart.
        repeat (6) step(1'b1, 1'b1, 2'd0, 1'b0);
        check("pre_dis_idx", 32'(bus.idx), 32'd2);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        check("dis_y", 32'(bus.y), 32'd0);
        check("dis_idx", 32'(bus.idx), 32'd2);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("restart_y", 32'(bus.y), 32'h1);
        check("restart_idx", 32'(bus.idx), 32'd0);

        // Switch to direct from a blank cycle.
        step(1'b1, 1'b1, 2'd0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        check("blank_y", 32'(bus.y), 32'd0);
        step(1'b1, 1'b0, 2'd2, 1'b1);
        check("modesw_y", 32'(bus.y), 32'h4);
        check("modesw_wrap", 32'(bus.wrap), 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        r_en   = 1'b1;
        r_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            r_en = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 24) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 299) == 0) begin
                async_reset_check();
                step(r_en, r_mode, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                rst_n = 1'b1;
            end else begin
                step(r_en, r_mode, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_dec_scan.md
PARAM_DEC_SCAN -- requirements
Module: param_dec_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 2: select width; output count N = 2**SEL_W; legal range 1..6.
REQ-002 SHALL have parameter SCAN_DIV, default 4: cycles each output is held in scan mode; legal range >= 1.
REQ-003 SHALL have parameter ACT_LOW, default 0: 0 = active-high y, 1 = active-low y (y inverted bitwise).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port en  input  1  block enable; 0 forces all outputs inactive.
REQ-007 SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 SHALL have port sel  input  SEL_W  index to decode in direct mode.
REQ-009 SHALL have port sel_vld  input  1  qualifies sel; sampled only in direct mode.
REQ-010 SHALL have port y  output  N  registered one-hot decode (polarity per ACT_LOW).
REQ-011 SHALL have port idx  output  SEL_W  registered current index.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse when scan index wraps N-1 -> 0.

Function
REQ-013 SHALL implement states IDLE, DIRECT, SCAN_HOLD, SCAN_BLANK, plus an internal hold counter div of width ceil(log2(SCAN_DIV)) (min 1).
REQ-014 SHALL drive y inactive (all 0, or all 1 if ACT_LOW) in IDLE and SCAN_BLANK; y = onehot(idx) in DIRECT and SCAN_HOLD; never more than one active bit.
REQ-015 SHALL register y, idx, wrap; no combinational path from any input to any output.
REQ-016 IDLE: en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN_HOLD with idx=0, div=0.
REQ-017 DIRECT: at an edge with sel_vld=1, idx <= sel; with sel_vld=0, idx retained; latency sel_vld sample -> y update = 1 cycle.
REQ-018 IDLE -> DIRECT edge SHALL also apply REQ-017 (sel captured if sel_vld=1 on that edge).
REQ-019 SCAN_HOLD: div increments each cycle; at div = SCAN_DIV-1 -> SCAN_BLANK, div <= 0.
REQ-020 SCAN_BLANK: exactly one cycle; -> SCAN_HOLD with idx <= (idx+1) mod N; wrap = 1 on that edge's output cycle iff idx was N-1.
REQ-021 Scan period per index SHALL be SCAN_DIV+1 cycles; full rotation N*(SCAN_DIV+1) cycles.
REQ-022 en=0 at any edge SHALL move to IDLE next edge; idx retained, div <= 0, wrap <= 0.
REQ-023 mode 0->1 while en=1 SHALL enter SCAN_HOLD idx=0, div=0 next edge; mode 1->0 SHALL enter DIRECT next edge per REQ-017.
REQ-024 sel_vld SHALL be ignored in IDLE, SCAN_HOLD and SCAN_BLANK.
REQ-025 With SEL_W=1 the block SHALL behave as a 1-to-2 decoder; with SCAN_DIV=1 each index SHALL be held 1 cycle then blanked 1 cycle.
REQ-026 wrap SHALL be 0 in every cycle except the one defined in REQ-020.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force state IDLE, idx=0, div=0, wrap=0, y inactive.
REQ-028 Reset release SHALL be sampled at clk; first state change no earlier than the first rising edge with rst_n=1.
REQ-029 Reset asserted mid-scan or mid-direct SHALL abandon the operation with no residual output pulse.

Verification (SEL_W=2, SCAN_DIV=2, ACT_LOW=0 unless stated)
REQ-030 Reset: rst_n=0 between edges with y=0100 -> y=0000, idx=0 without a clock edge.
REQ-031 Direct: en=1, mode=0, sel=3, sel_vld=1 for one edge -> y=1000, idx=3 next cycle; sel changed to 1 with sel_vld=0 -> y stays 1000.
REQ-032 Scan: en=1, mode=1 from IDLE -> y sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001; wrap=1 only on the final 0001 cycle.
REQ-033 Disable: en=0 during SCAN_HOLD idx=2 -> y=0000 next cycle, idx stays 2; en=1 again with mode=1 -> restart at idx=0.
REQ-034 Mode switch: scanning, mode->0 with sel=2, sel_vld=1 -> y=0100 next cycle, no blank cycle, wrap=0.
REQ-035 ACT_LOW=1, SEL_W=3: direct sel=5 -> y=8'b11011111; IDLE -> y=8'hFF.
